sram_access_arbiter: RTL and testbench
======================================

// Module: sram_access_arbiter
// PURPOSE
//   Shares the single 512Kx16 async SRAM (tristate bridge pins) between two masters: video scanout prefetch (read-only, high priority) and the decoder (read/write).
//   Sequences SRAM control strobes with programmable wait states.
//   Sits between the decoder/video datapath and the SRAM tristate conduit inside HW_QSYS.
// PARAMETERS
//   AW           19  SRAM word address width
//   DW           16  SRAM data width
//   RD_CYCLES    2   cycles ce_n/oe_n held low per read (>=1)
//   WR_CYCLES    2   cycles we_n held low per write (>=1)
//   STARVE_LIMIT 8   consecutive video grants while dec_req pending before dec is forced
// PORTS
//   clk          in   1   system clock (50 MHz domain)
//   reset        in   1   async, active-high
//   vid_req      in   1   video read request; hold with vid_addr until vid_gnt
//   vid_addr     in   AW  video word address
//   vid_gnt      out  1   1-cycle pulse: video request accepted
//   vid_rvalid   out  1   1-cycle pulse: vid_rdata valid
//   vid_rdata    out  DW  read data to video
//   dec_req      in   1   decoder request; hold all dec_* stable until dec_gnt
//   dec_wr       in   1   1=write, 0=read
//   dec_addr     in   AW  decoder word address
//   dec_wdata    in   DW  write data
//   dec_be       in   2   byte enables, active-high (bit1=upper byte)
//   dec_gnt      out  1   1-cycle pulse: decoder request accepted
//   dec_rvalid   out  1   1-cycle pulse: dec_rdata valid (reads only)
//   dec_rdata    out  DW  read data to decoder
//   sram_addr    out  AW  address pins
//   sram_dq_out  out  DW  data to pad
//   sram_dq_oe   out  1   1 = drive data pads
//   sram_dq_in   in   DW  data from pad
//   sram_ce_n / sram_oe_n / sram_we_n  out 1 each  active-low strobes
//   sram_be_n    out  2   active-low byte enables
// BEHAVIOUR
//   Reset: all gnt/rvalid=0, rdata=0, sram_addr=0, dq_out=0, dq_oe=0, ce_n/oe_n/we_n=1, be_n=2'b11,
//     starve_cnt=0, state=IDLE. Async reset mid-access aborts immediately; the aborted request is lost (no gnt replay).
//   States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, TURN.
//   IDLE arbitration (one decision per cycle):
//     vid wins if vid_req && !(dec_req && starve_cnt==STARVE_LIMIT); else dec if dec_req.
//     gnt pulses in the IDLE cycle; addr/wdata/be/wr latched same edge.
//     starve_cnt: +1 on vid grant while dec_req=1 (saturates at STARVE_LIMIT); cleared on dec grant or when dec_req=0.
//   Read: IDLE->RD; RD for RD_CYCLES cycles: ce_n=0, oe_n=0, be_n=2'b00 (all reads full word), dq_oe=0.
//     dq_in registered on last RD cycle into the owner's rdata; rvalid pulses the next cycle.
//     Latency gnt->rvalid = RD_CYCLES+1. RD->IDLE, so back-to-back reads issue every RD_CYCLES+1 cycles.
//   Write: WR_SETUP (1 cyc: ce_n=0, be_n=~be, dq_oe=1, we_n=1) -> WR_PULSE (WR_CYCLES: we_n=0)
//     -> WR_HOLD (1 cyc: we_n=1, dq/addr held) -> IDLE. Writes use no rvalid.
//   TURN: if a read is granted in the IDLE cycle directly after WR_HOLD, go IDLE->TURN (1 cyc, all strobes
//     inactive, dq_oe=0) ->RD. Bus contention is never permitted: dq_oe=1 and oe_n=0 never coincide.
//   dec_be==2'b00 write: still sequenced, we_n pulses with be_n=2'b11 (no-op to memory).
//   Outside active states strobes are inactive; sram_addr holds last value.
//   Requests arriving outside IDLE wait; a req deasserted before gnt is simply dropped.
// STRUCTURE
//   sram_arb_pkg: state enum, default AW/DW localparams, owner encoding (OWN_VID/OWN_DEC).
//   Single module; wait-state counter and starvation counter inline; no sub-module warranted.
// TESTING
//   1 vid_req addr=0x12345, dq_in=0xBEEF, RD_CYCLES=2 -> gnt at t, oe_n low t+1..t+2, vid_rvalid at t+3, vid_rdata=0xBEEF.
//   2 dec write addr=0x7FFFF data=0xA55A be=2'b01 -> we_n low exactly 2 cyc, be_n=2'b10, dq_oe=1 setup..hold, no rvalid.
//   3 vid_req and dec_req held continuously -> 8 vid grants then 1 dec grant, repeating; dec never waits >9 grants.
//   4 dec write then immediate vid read -> TURN cycle seen; assert never (dq_oe && !oe_n).
//   5 reset asserted mid WR_PULSE -> same cycle we_n=1, ce_n=1, dq_oe=0; after release IDLE, no stale gnt/rvalid.
//   6 random mixed traffic vs SRAM model -> every read returns last written data, per-owner rvalid order matches grant order.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the SRAM access arbiter: FSM states, owner
// encoding and the default SRAM geometry.
package sram_arb_pkg;

  localparam int unsigned DefAw = 19;
  localparam int unsigned DefDw = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StTurn
  } arb_state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_DEC = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_access_arbiter.sv
// Shares one async SRAM between the video prefetch (read-only, high priority)
// and the decoder (read/write), sequencing strobes with programmable wait states.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW           = DefAw,
  parameter int unsigned DW           = DefDw,
  parameter int unsigned RD_CYCLES    = 2,
  parameter int unsigned WR_CYCLES    = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          dec_req,
  input  logic          dec_wr,
  input  logic [AW-1:0] dec_addr,
  input  logic [DW-1:0] dec_wdata,
  input  logic [1:0]    dec_be,
  output logic          dec_gnt,
  output logic          dec_rvalid,
  output logic [DW-1:0] dec_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_out,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_in,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [1:0]    sram_be_n
);

  localparam int unsigned MaxCycles = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned StarveW   = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                after_hold_q;
  owner_e              owner_q;
  logic [1:0]          be_q;
  logic [AW-1:0]       addr_q;
  logic [DW-1:0]       wdata_q;
  logic                vid_rvalid_q, dec_rvalid_q;
  logic [DW-1:0]       vid_rdata_q, dec_rdata_q;

  logic idle, dec_starved, vid_win, dec_win, wr_win, rd_last, pulse_last;

  // One arbitration decision per IDLE cycle; grants are masked while in reset.
  always_comb begin
    idle        = (state_q == StIdle) && !reset;
    dec_starved = dec_req && (starve_q == StarveW'(STARVE_LIMIT));
    vid_win     = idle && vid_req && !dec_starved;
    dec_win     = idle && dec_req && !vid_win;
    wr_win      = dec_win && dec_wr;
    rd_last     = (state_q == StRd) && (cnt_q == CntW'(RD_CYCLES - 1));
    pulse_last  = (state_q == StWrPulse) && (cnt_q == CntW'(WR_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      starve_q     <= '0;
      after_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      after_hold_q <= (state_q == StWrHold);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_win) begin
          state_d = StWrSetup;
        end else if (vid_win || dec_win) begin
          // A read right after a write gets a dead cycle so the pads turn around.
          state_d = after_hold_q ? StTurn : StRd;
        end
      end
      StRd:      if (rd_last) state_d = StIdle;
      StWrSetup: state_d = StWrPulse;
      StWrPulse: if (pulse_last) state_d = StWrHold;
      StWrHold:  state_d = StIdle;
      StTurn:    state_d = StRd;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q == StRd && !rd_last) || (state_q == StWrPulse && !pulse_last)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!dec_req || dec_win) begin
      starve_d = '0;
    end else if (vid_win && !dec_starved) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_VID;
      be_q         <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      vid_rvalid_q <= 1'b0;
      dec_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      dec_rdata_q  <= '0;
    end else begin
      if (vid_win || dec_win) begin
        owner_q <= vid_win ? OWN_VID : OWN_DEC;
        addr_q  <= vid_win ? vid_addr : dec_addr;
      end
      if (wr_win) begin
        wdata_q <= dec_wdata;
        be_q    <= dec_be;
      end
      vid_rvalid_q <= rd_last && (owner_q == OWN_VID);
      dec_rvalid_q <= rd_last && (owner_q == OWN_DEC);
      if (rd_last && owner_q == OWN_VID) vid_rdata_q <= sram_dq_in;
      if (rd_last && owner_q == OWN_DEC) dec_rdata_q <= sram_dq_in;
    end
  end

  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_be_n  = 2'b11;
    sram_dq_oe = 1'b0;
    unique case (state_q)
      StRd: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 2'b00;
      end
      StWrSetup, StWrHold: begin
        sram_ce_n  = 1'b0;
        sram_be_n  = ~be_q;
        sram_dq_oe = 1'b1;
      end
      StWrPulse: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_be_n  = ~be_q;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  assign vid_gnt     = vid_win;
  assign dec_gnt     = dec_win;
  assign vid_rvalid  = vid_rvalid_q;
  assign dec_rvalid  = dec_rvalid_q;
  assign vid_rdata   = vid_rdata_q;
  assign dec_rdata   = dec_rdata_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: table-driven single transactions, hand-written
// timing sequences and random traffic, checked against a reference memory scoreboard.
module tb_sram_access_arbiter;

  localparam int RdC = 2;
  localparam int WrC = 2;

  logic        clk, reset;
  logic        vid_req, vid_gnt, vid_rvalid;
  logic [18:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        dec_req, dec_wr, dec_gnt, dec_rvalid;
  logic [18:0] dec_addr;
  logic [15:0] dec_wdata, dec_rdata;
  logic [1:0]  dec_be;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;

  sram_access_arbiter #(
    .AW(19), .DW(16), .RD_CYCLES(RdC), .WR_CYCLES(WrC), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .dec_req(dec_req), .dec_wr(dec_wr), .dec_addr(dec_addr), .dec_wdata(dec_wdata),
    .dec_be(dec_be), .dec_gnt(dec_gnt), .dec_rvalid(dec_rvalid), .dec_rdata(dec_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #4;
  endtask

  // SRAM pin model: combinational read, byte-masked write while we_n is low.
  logic [15:0] mem [0:(1<<19)-1];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;
  initial forever begin
    @(negedge clk);
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_addr][7:0] = sram_dq_out[7:0];
      if (!sram_be_n[1]) mem[sram_addr][15:8] = sram_dq_out[15:8];
    end
  end

  // Reference memory and per-owner expected-read queues.
  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic [15:0] ref_mem [int];
  exp_t        vq[$];
  exp_t        dq[$];
  int          contention = 0;
  int          vg_cnt = 0;
  int          dg_cnt = 0;
  int          last_wr_cyc = -100;

  function automatic logic [15:0] ref_rd(input logic [18:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [15:0] w;
    int          lat;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sram_dq_oe && !sram_oe_n) contention++;
        lat = RdC + 1 + ((cyc == last_wr_cyc + WrC + 3) ? 1 : 0);
        if (vid_gnt) begin
          vg_cnt++;
          e.data = ref_rd(vid_addr);
          e.cyc  = cyc + lat;
          vq.push_back(e);
        end
        if (dec_gnt) begin
          dg_cnt++;
          if (dec_wr) begin
            w = ref_rd(dec_addr);
            if (dec_be[0]) w[7:0] = dec_wdata[7:0];
            if (dec_be[1]) w[15:8] = dec_wdata[15:8];
            ref_mem[int'(dec_addr)] = w;
            last_wr_cyc = cyc;
          end else begin
            e.data = ref_rd(dec_addr);
            e.cyc  = cyc + lat;
            dq.push_back(e);
          end
        end
        if (vid_rvalid) begin
          chk("vid_rvalid_expected", 32'(vq.size() != 0), 32'd1);
          if (vq.size() != 0) begin
            e = vq.pop_front();
            chk("vid_rdata", 32'(vid_rdata), 32'(e.data));
            chk("vid_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        if (dec_rvalid) begin
          chk("dec_rvalid_expected", 32'(dq.size() != 0), 32'd1);
          if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("dec_rdata", 32'(dec_rdata), 32'(e.data));
            chk("dec_rvalid_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        vreq;
    logic        dreq;
    logic        dwr;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        exp_vgnt;
    logic        exp_dgnt;
    logic [1:0]  exp_be_n;
  } vec_t;

  vec_t vecs[15];

  initial begin : main
    int got, gcyc, wcyc, vg_last, dg_last;
    logic found;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 19'h12345, 16'hBEEF, 2'b11, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 19'h12345, 16'h0000, 2'b00, 1'b1, 1'b0, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 19'h7FFFF, 16'h0000, 2'b11, 1'b0, 1'b1, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 19'h7FFFF, 16'hA55A, 2'b01, 1'b0, 1'b1, 2'b10};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 19'h7FFFF, 16'h0000, 2'b00, 1'b0, 1'b1, 2'b00};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 19'h12345, 16'h9999, 2'b11, 1'b1, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 19'h00100, 16'hFFFF, 2'b11, 1'b0, 1'b1, 2'b00};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 19'h00100, 16'hC3D4, 2'b10, 1'b0, 1'b1, 2'b01};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 19'h00100, 16'h0000, 2'b00, 1'b1, 1'b0, 2'b00};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 19'h12345, 16'h1111, 2'b00, 1'b0, 1'b1, 2'b11};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 19'h12345, 16'h0000, 2'b00, 1'b1, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 19'h00000, 16'h1234, 2'b11, 1'b0, 1'b1, 2'b00};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 19'h00000, 16'h0000, 2'b00, 1'b0, 1'b1, 2'b00};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 19'h00000, 16'h0000, 2'b00, 1'b1, 1'b0, 2'b00};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 19'h00100, 16'h0000, 2'b00, 1'b0, 1'b1, 2'b00};

    // Reset state, with a video request present that must not be granted.
    reset = 1'b1;
    vid_req = 1'b1; vid_addr = 19'h0; dec_req = 1'b0; dec_wr = 1'b0;
    dec_addr = 19'h0; dec_wdata = 16'h0; dec_be = 2'b00;
    tick(); tick(); sample();
    chk("rst_vid_gnt", 32'(vid_gnt), 32'd0);
    chk("rst_dec_gnt", 32'(dec_gnt), 32'd0);
    chk("rst_rvalid", 32'({vid_rvalid, dec_rvalid}), 32'd0);
    chk("rst_rdata", 32'({vid_rdata, dec_rdata}), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    chk("rst_be_n", 32'(sram_be_n), 32'h3);
    tick();
    vid_req = 1'b0;
    reset = 1'b0;
    repeat (2) tick();

    // Table: one transaction each from a quiet IDLE.
    for (int i = 0; i < 15; i++) begin
      vid_req = vecs[i].vreq; vid_addr = vecs[i].addr;
      dec_req = vecs[i].dreq; dec_wr = vecs[i].dwr; dec_addr = vecs[i].addr;
      dec_wdata = vecs[i].wdata; dec_be = vecs[i].be;
      sample();
      chk($sformatf("vec%0d_vid_gnt", i), 32'(vid_gnt), 32'(vecs[i].exp_vgnt));
      chk($sformatf("vec%0d_dec_gnt", i), 32'(dec_gnt), 32'(vecs[i].exp_dgnt));
      tick();
      vid_req = 1'b0; dec_req = 1'b0;
      sample();
      chk($sformatf("vec%0d_be_n", i), 32'(sram_be_n), 32'(vecs[i].exp_be_n));
      chk($sformatf("vec%0d_sram_addr", i), 32'(sram_addr), 32'(vecs[i].addr));
      repeat (6) tick();
    end

    // Read timing: gnt at t, oe_n low t+1..t+2, rvalid with data at t+3.
    vid_req = 1'b1; vid_addr = 19'h12345;
    sample();
    chk("rd_gnt", 32'(vid_gnt), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      vid_req = 1'b0;
      sample();
      chk($sformatf("rd_oe_n_t%0d", k), 32'(sram_oe_n), 32'(k == 3));
      chk($sformatf("rd_rvalid_t%0d", k), 32'(vid_rvalid), 32'(k == 3));
      if (k == 3) chk("rd_rdata", 32'(vid_rdata), 32'hBEEF);
    end
    repeat (3) tick();

    // Write strobe sequence for be=01.
    dec_req = 1'b1; dec_wr = 1'b1; dec_addr = 19'h7FFFF; dec_wdata = 16'hA55A; dec_be = 2'b01;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (k == 0) chk("wr_gnt", 32'(dec_gnt), 32'd1);
      chk($sformatf("wr_we_n_%0d", k), 32'(sram_we_n), 32'(!(k == 2 || k == 3)));
      chk($sformatf("wr_dq_oe_%0d", k), 32'(sram_dq_oe), 32'(k >= 1 && k <= 4));
      chk($sformatf("wr_be_n_%0d", k), 32'(sram_be_n), (k >= 1 && k <= 4) ? 32'h2 : 32'h3);
      chk($sformatf("wr_rvalid_%0d", k), 32'({vid_rvalid, dec_rvalid}), 32'd0);
      if (k == 2) chk("wr_dq_out", 32'(sram_dq_out), 32'hA55A);
      tick();
      dec_req = 1'b0;
    end
    repeat (2) tick();

    // Starvation: both held, expect 8 video grants then 1 decoder grant, twice.
    vid_req = 1'b1; vid_addr = 19'h12345;
    dec_req = 1'b1; dec_wr = 1'b0; dec_addr = 19'h00000;
    got = 0;
    for (int c = 0; c < 250 && got < 18; c++) begin
      sample();
      if (vid_gnt || dec_gnt) begin
        chk($sformatf("starve_grant%0d_is_dec", got), 32'(dec_gnt), 32'((got % 9) == 8));
        got++;
      end
      tick();
    end
    chk("starve_grant_count", 32'(got), 32'd18);
    vid_req = 1'b0; dec_req = 1'b0;
    repeat (8) tick();

    // Write followed immediately by a video read: expect a TURN cycle.
    dec_req = 1'b1; dec_wr = 1'b1; dec_addr = 19'h00200; dec_wdata = 16'h5A5A; dec_be = 2'b11;
    sample();
    chk("turn_wr_gnt", 32'(dec_gnt), 32'd1);
    wcyc = cyc;
    tick();
    dec_req = 1'b0; vid_req = 1'b1; vid_addr = 19'h00200;
    found = 1'b0;
    gcyc = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      sample();
      if (vid_gnt) begin
        found = 1'b1;
        gcyc = cyc;
      end else begin
        tick();
      end
    end
    chk("turn_vid_gnt_seen", 32'(found), 32'd1);
    chk("turn_vid_gnt_delay", 32'(gcyc - wcyc), 32'd5);
    tick();
    vid_req = 1'b0;
    sample();
    chk("turn_strobes_idle", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    chk("turn_dq_oe", 32'(sram_dq_oe), 32'd0);
    tick();
    sample();
    chk("turn_then_rd_oe_n", 32'(sram_oe_n), 32'd0);
    repeat (4) tick();

    // Reset during the write pulse aborts the access at once.
    dec_req = 1'b1; dec_wr = 1'b1; dec_addr = 19'h55555; dec_wdata = 16'hFFFF; dec_be = 2'b11;
    sample();
    chk("abort_wr_gnt", 32'(dec_gnt), 32'd1);
    tick();
    dec_req = 1'b0;
    tick();
    sample();
    chk("abort_in_pulse", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("abort_quiet%0d", k),
          32'({vid_gnt, dec_gnt, vid_rvalid, dec_rvalid, sram_ce_n}), 32'h1);
      tick();
    end
    vid_req = 1'b1; vid_addr = 19'h12345;
    sample();
    chk("abort_idle_gnt", 32'(vid_gnt), 32'd1);
    tick();
    vid_req = 1'b0;
    repeat (4) tick();

    // Random traffic over a small address pool, seeded with full-word writes.
    for (int a = 0; a < 8; a++) begin
      dec_req = 1'b1; dec_wr = 1'b1; dec_addr = 19'(32'h10 + a);
      dec_wdata = 16'($urandom); dec_be = 2'b11;
      sample();
      chk($sformatf("seed%0d_gnt", a), 32'(dec_gnt), 32'd1);
      tick();
      dec_req = 1'b0;
      repeat (5) tick();
    end
    vg_last = vg_cnt;
    dg_last = dg_cnt;
    for (int c = 0; c < 800; c++) begin
      if (!vid_req || vg_cnt != vg_last) begin
        vg_last  = vg_cnt;
        vid_req  = ($urandom_range(0, 1) == 1);
        vid_addr = 19'(32'h10 + $urandom_range(0, 7));
      end
      if (!dec_req || dg_cnt != dg_last) begin
        dg_last   = dg_cnt;
        dec_req   = ($urandom_range(0, 1) == 1);
        dec_wr    = ($urandom_range(0, 1) == 1);
        dec_addr  = 19'(32'h10 + $urandom_range(0, 7));
        dec_wdata = 16'($urandom);
        dec_be    = 2'($urandom_range(0, 3));
      end
      tick();
    end
    vid_req = 1'b0; dec_req = 1'b0;
    for (int c = 0; c < 60 && (vq.size() != 0 || dq.size() != 0); c++) tick();
    repeat (3) tick();
    chk("drain_vid_queue", 32'(vq.size()), 32'd0);
    chk("drain_dec_queue", 32'(dq.size()), 32'd0);
    chk("no_bus_contention", 32'(contention), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
